// File: rtl/eth_rx_stats.sv
// rtl/eth_rx_stats.sv - RX frame classifier, statistics counters, snapshot and LED stretcher
module eth_rx_stats #(
  parameter int CNT_W          = 32,
  parameter int LEN_W          = 16,
  parameter int MIN_LEN        = 64,
  parameter int MAX_LEN        = 1518,
  parameter int SATURATE       = 1,
  parameter int CLEAR_ON_SNAP  = 1,
  parameter int STRETCH_W      = 24,
  parameter int STRETCH_CYCLES = 12500000,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic             gmii_rx_clk,
  input  logic             btn_rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  input  logic             snap_req,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_frames,
  output logic [CNT_W-1:0] snap_good,
  output logic [CNT_W-1:0] snap_errs,
  output logic [CNT_W-1:0] snap_runts,
  output logic [CNT_W-1:0] snap_giants,
  output logic [CNT_W-1:0] snap_bytes,
  output logic             led_act,
  output logic             led_err
);

  // Counter slots: frames, good, errs, runts, giants, good bytes
  localparam int NCNT     = 6;
  localparam int C_FRAMES = 0;
  localparam int C_GOOD   = 1;
  localparam int C_ERRS   = 2;
  localparam int C_RUNTS  = 3;
  localparam int C_GIANTS = 4;
  localparam int C_BYTES  = 5;

  // Sum width wide enough that counter + frame length never overflows before the clamp test
  localparam int                 SUM_W      = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0]   LEN_MAX    = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0]   MIN_L      = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]   MAX_L      = LEN_W'(MAX_LEN);
  localparam logic [STRETCH_W-1:0] STRETCH_LD = STRETCH_W'(STRETCH_CYCLES);
  localparam logic               LED_OFF    = (LED_ACTIVE_LOW != 0);

  logic [LEN_W-1:0]     len_q, len_d, frame_len;
  logic                 is_last, is_runt, is_giant;
  logic                 inc_err, inc_runt, inc_giant, inc_good;
  logic                 clr_live;
  logic [CNT_W-1:0]     cnt_q  [NCNT];
  logic [CNT_W-1:0]     cnt_d  [NCNT];
  logic [CNT_W-1:0]     snap_q [NCNT];
  logic [SUM_W-1:0]     amt    [NCNT];
  logic                 snap_valid_q;
  logic [STRETCH_W-1:0] act_q, act_d, err_q, err_d;
  logic                 led_act_q, led_err_q;

  // Frame bytes are never inspected; only the beat count matters
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;

  // Add to a counter, either sticking at all-ones or wrapping
  function automatic logic [CNT_W-1:0] add_cnt(input logic [CNT_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    if (SATURATE != 0 && s > SUM_W'(CNT_MAX)) return CNT_MAX;
    return s[CNT_W-1:0];
  endfunction

  // Length tracking and classification of the frame ending on this beat
  always_comb begin
    is_last   = s_axis_tvalid & s_axis_tlast;
    frame_len = (len_q == LEN_MAX) ? LEN_MAX : len_q + LEN_W'(1);
    len_d     = len_q;
    if (s_axis_tvalid) len_d = s_axis_tlast ? '0 : frame_len;
    is_runt   = (frame_len < MIN_L);
    is_giant  = (frame_len > MAX_L);
    inc_err   = is_last & s_axis_tuser;
    inc_runt  = is_last & ~s_axis_tuser & is_runt;
    inc_giant = is_last & ~s_axis_tuser & ~is_runt & is_giant;
    inc_good  = is_last & ~s_axis_tuser & ~is_runt & ~is_giant;
  end

  // Live counter next state; a snapshot clear happens first so a coincident frame is kept
  always_comb begin
    clr_live         = snap_req & (CLEAR_ON_SNAP != 0);
    amt[C_FRAMES]    = SUM_W'(is_last);
    amt[C_GOOD]      = SUM_W'(inc_good);
    amt[C_ERRS]      = SUM_W'(inc_err);
    amt[C_RUNTS]     = SUM_W'(inc_runt);
    amt[C_GIANTS]    = SUM_W'(inc_giant);
    amt[C_BYTES]     = inc_good ? SUM_W'(frame_len) : '0;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = add_cnt(clr_live ? '0 : cnt_q[i], amt[i]);
    end
  end

  // LED stretch counters: reload on trigger, otherwise count down to zero
  always_comb begin
    act_d = (act_q != '0) ? act_q - STRETCH_W'(1) : '0;
    err_d = (err_q != '0) ? err_q - STRETCH_W'(1) : '0;
    if (is_last) act_d = STRETCH_LD;
    if (inc_err | inc_runt | inc_giant) err_d = STRETCH_LD;
  end

  // Register length, live counters, snapshot copy, stretch counters and LED levels
  always_ff @(posedge gmii_rx_clk or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      len_q        <= '0;
      snap_valid_q <= 1'b0;
      act_q        <= '0;
      err_q        <= '0;
      led_act_q    <= LED_OFF;
      led_err_q    <= LED_OFF;
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      len_q        <= len_d;
      snap_valid_q <= snap_req;
      act_q        <= act_d;
      err_q        <= err_d;
      led_act_q    <= (act_d != '0) ^ LED_OFF;
      led_err_q    <= (err_d != '0) ^ LED_OFF;
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_req) snap_q[i] <= cnt_q[i];
      end
    end
  end

  assign snap_valid  = snap_valid_q;
  assign snap_frames = snap_q[C_FRAMES];
  assign snap_good   = snap_q[C_GOOD];
  assign snap_errs   = snap_q[C_ERRS];
  assign snap_runts  = snap_q[C_RUNTS];
  assign snap_giants = snap_q[C_GIANTS];
  assign snap_bytes  = snap_q[C_BYTES];
  assign led_act     = led_act_q;
  assign led_err     = led_err_q;

endmodule

// File: tb/tb_eth_rx_stats.sv
// tb/tb_eth_rx_stats.sv - scoreboard bench for eth_rx_stats
module tb_eth_rx_stats;
  localparam int S = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tdata = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, snap_req = 1'b0;

  logic        m_valid, m_act, m_err;
  logic [31:0] m_frames, m_good, m_errs, m_runts, m_giants, m_bytes;
  logic        s_valid, s_act, s_err;
  logic [3:0]  s_frames, s_good, s_errs, s_runts, s_giants, s_bytes;
  logic        w_valid, w_act, w_err;
  logic [3:0]  w_frames, w_good, w_errs, w_runts, w_giants, w_bytes;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    longint frames, good, errs, runts, giants, bytes;
  } snap_t;
  snap_t exp_q[$];
  snap_t m;
  int    m_len = 0;

  always #5 clk = ~clk;

  eth_rx_stats #(.CNT_W(32), .STRETCH_W(8), .STRETCH_CYCLES(S)) u_main (
    .gmii_rx_clk(clk), .btn_rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .snap_req(snap_req), .snap_valid(m_valid),
    .snap_frames(m_frames), .snap_good(m_good), .snap_errs(m_errs), .snap_runts(m_runts),
    .snap_giants(m_giants), .snap_bytes(m_bytes), .led_act(m_act), .led_err(m_err));

  eth_rx_stats #(.CNT_W(4), .SATURATE(1), .STRETCH_W(8), .STRETCH_CYCLES(S)) u_sat (
    .gmii_rx_clk(clk), .btn_rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .snap_req(snap_req), .snap_valid(s_valid),
    .snap_frames(s_frames), .snap_good(s_good), .snap_errs(s_errs), .snap_runts(s_runts),
    .snap_giants(s_giants), .snap_bytes(s_bytes), .led_act(s_act), .led_err(s_err));

  eth_rx_stats #(.CNT_W(4), .SATURATE(0), .STRETCH_W(8), .STRETCH_CYCLES(S)) u_wrap (
    .gmii_rx_clk(clk), .btn_rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .snap_req(snap_req), .snap_valid(w_valid),
    .snap_frames(w_frames), .snap_good(w_good), .snap_errs(w_errs), .snap_runts(w_runts),
    .snap_giants(w_giants), .snap_bytes(w_bytes), .led_act(w_act), .led_err(w_err));

  string       fname [6] = '{"frames", "good", "errs", "runts", "giants", "bytes"};
  snap_t       mon_e;
  longint      mon_w [6];
  logic [31:0] mon_m [6];
  logic [3:0]  mon_s [6];
  logic [3:0]  mon_x [6];

  // Scoreboard: pop the expected snapshot whenever the DUTs publish one
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL snap_unexpected: snap_valid=1 with no request pending");
      end else begin
        mon_e = exp_q.pop_front();
        mon_w = '{mon_e.frames, mon_e.good, mon_e.errs, mon_e.runts, mon_e.giants, mon_e.bytes};
        mon_m = '{m_frames, m_good, m_errs, m_runts, m_giants, m_bytes};
        mon_s = '{s_frames, s_good, s_errs, s_runts, s_giants, s_bytes};
        mon_x = '{w_frames, w_good, w_errs, w_runts, w_giants, w_bytes};
        for (int i = 0; i < 6; i++) begin
          n_checks++;
          if (mon_m[i] !== 32'(mon_w[i])) begin
            n_errors++;
            $display("FAIL snap_%s: got %0d want %0d", fname[i], mon_m[i], mon_w[i]);
          end
          n_checks++;
          if (mon_s[i] !== 4'((mon_w[i] > 15) ? 15 : mon_w[i])) begin
            n_errors++;
            $display("FAIL sat4_%s: got %0d want %0d", fname[i], mon_s[i],
                     (mon_w[i] > 15) ? 15 : mon_w[i]);
          end
          n_checks++;
          if (mon_x[i] !== 4'(mon_w[i] & 15)) begin
            n_errors++;
            $display("FAIL wrap4_%s: got %0d want %0d", fname[i], mon_x[i], mon_w[i] & 15);
          end
        end
      end
    end
  end

  // One clock of stimulus; the model is updated in snapshot-then-clear-then-frame order
  task automatic step(input bit v, input bit l, input bit u, input bit s);
    int nl;
    if (s) begin
      exp_q.push_back(m);
      m = '{default: 0};
    end
    if (v) begin
      nl = (m_len + 1 > 65535) ? 65535 : m_len + 1;
      if (l) begin
        m.frames++;
        if (u) m.errs++;
        else if (nl < 64) m.runts++;
        else if (nl > 1518) m.giants++;
        else begin m.good++; m.bytes += nl; end
        m_len = 0;
      end else begin
        m_len = nl;
      end
    end
    tvalid = v; tlast = l; tuser = u; snap_req = s; tdata = 8'($urandom);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; snap_req = 1'b0;
    if (s) begin
      n_checks++;
      if (m_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL snap_latency: snap_valid got %b want 1", m_valid);
      end
    end
  endtask

  task automatic send_frame(input int len, input bit err, input bit gaps);
    for (int i = 1; i <= len; i++) begin
      if (gaps && i > 1) step(0, 0, 0, 0);
      step(1, i == len, err && i == len, 0);
    end
  endtask

  // Request a snapshot, let the scoreboard consume it, then confirm nothing is left pending
  task automatic snap_and_drain(input string tag);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: pending snapshots got %0d want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    logic [31:0] v [6];
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v = '{m_frames, m_good, m_errs, m_runts, m_giants, m_bytes};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (v[i] !== 32'd0) begin
        n_errors++;
        $display("FAIL reset_%s: got %0d want 0", fname[i], v[i]);
      end
    end
    n_checks++;
    if ({m_valid, m_act, m_err} !== 3'b011) begin
      n_errors++;
      $display("FAIL reset_ctl: {valid,act,err} got %b want 011", {m_valid, m_act, m_err});
    end
    m = '{default: 0}; m_len = 0; exp_q.delete();
    rst_n = 1'b1;
    step(0, 0, 0, 0);
  endtask

  task automatic test_clean_frames;
    for (int f = 0; f < 3; f++) send_frame(64, 0, 0);
    n_checks++;
    if (m_act !== 1'b0) begin
      n_errors++;
      $display("FAIL clean_led_act: got %b want 0", m_act);
    end
    snap_and_drain("clean");
  endtask

  task automatic test_errors;
    int on_cnt;
    send_frame(63, 0, 0);
    send_frame(1519, 0, 0);
    send_frame(1, 0, 0);
    send_frame(100, 1, 0);
    on_cnt = 0;
    for (int k = 0; k < S + 5; k++) begin
      if (m_err === 1'b0) on_cnt++;
      step(0, 0, 0, 0);
    end
    n_checks++;
    if (on_cnt < S - 1 || on_cnt > S + 1) begin
      n_errors++;
      $display("FAIL led_err_stretch: on cycles got %0d want %0d", on_cnt, S);
    end
    n_checks++;
    if (m_err !== 1'b1) begin
      n_errors++;
      $display("FAIL led_err_off: got %b want 1", m_err);
    end
    snap_and_drain("errors");
  endtask

  task automatic test_snap_coincide;
    for (int i = 1; i < 64; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    snap_and_drain("b2b");
  endtask

  task automatic test_gap_frame;
    send_frame(200, 0, 1);
    snap_and_drain("gap");
  endtask

  task automatic test_saturation;
    for (int f = 0; f < 20; f++) send_frame(64, 0, 0);
    snap_and_drain("sat");
  endtask

  task automatic test_reset_midframe;
    logic [31:0] v [6];
    send_frame(70, 1, 0);
    step(1, 0, 0, 1);
    for (int i = 2; i <= 20; i++) step(1, 0, 0, 0);
    n_checks++;
    if (m_err !== 1'b0) begin
      n_errors++;
      $display("FAIL pre_reset_led_err: got %b want 0", m_err);
    end
    rst_n = 1'b0;
    #2;
    v = '{m_frames, m_good, m_errs, m_runts, m_giants, m_bytes};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (v[i] !== 32'd0) begin
        n_errors++;
        $display("FAIL midreset_%s: got %0d want 0", fname[i], v[i]);
      end
    end
    n_checks++;
    if ({m_valid, m_act, m_err} !== 3'b011) begin
      n_errors++;
      $display("FAIL midreset_ctl: {valid,act,err} got %b want 011", {m_valid, m_act, m_err});
    end
    repeat (2) @(posedge clk);
    #1;
    m = '{default: 0}; m_len = 0; exp_q.delete();
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) step(1, i == 30, 0, 0);
    snap_and_drain("midreset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_frames();
    test_errors();
    test_snap_coincide();
    test_back_to_back();
    test_gap_frame();
    test_saturation();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
